instr_queue: RTL and testbench

INSTR_QUEUE -- requirements
Module: instr_queue

---
 rtl/instr_queue.sv | 91 +++++++++
 tb/tb_instr_queue.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/instr_queue.sv
// Instruction queue between the instruction selector and decode: a DEPTH-entry
// circular FIFO of {instr, pc} with NOP/0 presented on the head while empty.
package mmm_pkg;
    localparam int ILEN = 32;
    localparam int XLEN = 32;
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } iq_entry_t;
endpackage

module instr_queue
    import mmm_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     flush_i,
    input  logic [ILEN-1:0]          instr_i,
    input  logic [XLEN-1:0]          pc_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    output logic [ILEN-1:0]          instr_o,
    output logic [XLEN-1:0]          pc_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    iq_entry_t         r_mem [DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic              w_push;
    logic              w_pop;
    iq_entry_t         w_head;

    // Handshakes depend only on registered occupancy: no full or empty bypass.
    assign ready_o = (r_count < CW'(DEPTH));
    assign valid_o = (r_count != '0);
    assign w_push  = valid_i && ready_o;
    assign w_pop   = valid_o && ready_i;
    assign count_o = r_count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; reset is sampled synchronously here.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage has no reset; stale slots are never visible because the
    // head is masked to NOP/0 whenever the queue is empty.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= '{instr: instr_i, pc: pc_i};
        end
    end

    // NOTE: defaults first so the combinational head mux cannot infer a latch.
    always_comb begin
        w_head  = r_mem[r_rptr];
        instr_o = NOP_INSTR;
        pc_o    = '0;
        if (valid_o) begin
            instr_o = w_head.instr;
            pc_o    = w_head.pc;
        end
    end
endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a queue model.
module tb_instr_queue;
    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] instr_in = '0;
    logic [31:0] pc_in = '0;
    logic        valid_in = 1'b0;
    logic        ready_in = 1'b0;
    logic        ready_out;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        valid_out;
    logic [2:0]  count_out;

    int n_cmp = 0;
    int n_err = 0;

    // Reference: an ordered list of {instr, pc}; occupancy is its size.
    logic [63:0] model_q [$];
    bit          model_live = 1'b0;

    instr_queue #(.DEPTH(DEPTH)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .flush_i (flush),
        .instr_i (instr_in),
        .pc_i    (pc_in),
        .valid_i (valid_in),
        .ready_o (ready_out),
        .instr_o (instr_out),
        .pc_o    (pc_out),
        .valid_o (valid_out),
        .ready_i (ready_in),
        .count_o (count_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update from the inputs seen at the rising edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            model_q.delete();
            model_live <= 1'b1;
        end else if (model_live) begin
            if (flush) begin
                model_q.delete();
            end else begin
                bit do_pop;
                bit do_push;
                do_pop  = (model_q.size() != 0) && ready_in;
                do_push = valid_in && (model_q.size() < DEPTH);
                if (do_pop)  void'(model_q.pop_front());
                if (do_push) model_q.push_back({instr_in, pc_in});
            end
        end
    end

    // Compare process: away from the active edge, every cycle once the model is live.
    always @(negedge clk) begin
        if (model_live) begin
            int sz;
            sz = model_q.size();
            check("m_count", 64'(count_out), 64'(sz));
            check("m_ready", 64'(ready_out), 64'(sz < DEPTH));
            check("m_valid", 64'(valid_out), 64'(sz != 0));
            check("m_instr", 64'(instr_out), (sz != 0) ? 64'(model_q[0][63:32]) : 64'(NOP));
            check("m_pc",    64'(pc_out),    (sz != 0) ? 64'(model_q[0][31:0])  : 64'd0);
        end
    end

    // Apply one cycle of inputs; returns at posedge+1 with the new state settled.
    task automatic cyc(input bit r, input bit f, input bit v, input logic [31:0] ins,
                       input logic [31:0] pc, input bit rdy);
        rst_n = r; flush = f; valid_in = v; instr_in = ins; pc_in = pc; ready_in = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit rdy);
        cyc(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'hFFFF_FFFF, rdy);
    endtask

    initial begin
        @(posedge clk); #1;
        cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 32'h1111_1111, 32'h4, 1'b1);
        check("rst_count", 64'(count_out), 64'd0);
        check("rst_ready", 64'(ready_out), 64'd1);
        check("rst_valid", 64'(valid_out), 64'd0);
        check("rst_instr", 64'(instr_out), 64'(NOP));
        check("rst_pc",    64'(pc_out),    64'd0);

        // Single push into empty queue, decode not ready.
        cyc(1'b1, 1'b0, 1'b1, 32'hA000_000A, 32'h100, 1'b0);
        check("push1_valid", 64'(valid_out), 64'd1);
        check("push1_instr", 64'(instr_out), 64'h A000_000A);
        check("push1_pc",    64'(pc_out),    64'h100);
        check("push1_count", 64'(count_out), 64'd1);

        // Fill to DEPTH, then a refused fifth push.
        for (int i = 1; i < DEPTH; i++) cyc(1'b1, 1'b0, 1'b1, 32'hA000_0000 + i, 32'h100 + 4 * i, 1'b0);
        check("full_count", 64'(count_out), 64'd4);
        check("full_ready", 64'(ready_out), 64'd0);
        cyc(1'b1, 1'b0, 1'b1, 32'hBAD0_0005, 32'h200, 1'b0);
        check("ovf_count", 64'(count_out), 64'd4);
        check("ovf_head",  64'(instr_out), 64'h A000_000A);

        // Full with push and pop together: only the pop happens.
        cyc(1'b1, 1'b0, 1'b1, 32'hBAD0_0006, 32'h204, 1'b1);
        check("fullpp_count", 64'(count_out), 64'd3);
        check("fullpp_ready", 64'(ready_out), 64'd1);
        check("fullpp_head",  64'(pc_out),    64'h104);

        // Flush overrides simultaneous push and pop.
        cyc(1'b1, 1'b1, 1'b1, 32'hBAD0_0007, 32'h208, 1'b1);
        check("flush_count", 64'(count_out), 64'd0);
        check("flush_valid", 64'(valid_out), 64'd0);
        check("flush_instr", 64'(instr_out), 64'(NOP));

        // Push while empty with ready_i=1 must not pop in the same cycle.
        cyc(1'b1, 1'b0, 1'b1, 32'hC000_0000, 32'h300, 1'b1);
        check("empty_push_count", 64'(count_out), 64'd1);
        cyc(1'b1, 1'b0, 1'b1, 32'hC000_0001, 32'h304, 1'b0);
        for (int i = 2; i < 12; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 32'hC000_0000 + i, 32'h300 + 4 * i, 1'b1);
            check("stream_count", 64'(count_out), 64'd2);
            check("stream_pc",    64'(pc_out),    64'(32'h300 + 4 * (i - 1)));
        end

        // Reset with a full queue, then a fresh push is read first.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 1'b1, 32'hD000_0000 + i, 32'h400 + 4 * i, 1'b0);
        check("prerst_count", 64'(count_out), 64'd4);
        cyc(1'b0, 1'b0, 1'b1, 32'hBAD0_0008, 32'h20C, 1'b1);
        check("midrst_count", 64'(count_out), 64'd0);
        check("midrst_ready", 64'(ready_out), 64'd1);
        check("midrst_valid", 64'(valid_out), 64'd0);
        check("midrst_pc",    64'(pc_out),    64'd0);
        cyc(1'b1, 1'b0, 1'b1, 32'hE000_0000, 32'h500, 1'b0);
        check("postrst_instr", 64'(instr_out), 64'h E000_0000);
        check("postrst_pc",    64'(pc_out),    64'h500);
        idle(1'b1);
        check("postrst_drain", 64'(count_out), 64'd0);

        // Randomized traffic with phases of different push/pop bias.
        for (int i = 0; i < 3000; i++) begin
            int vb;
            int rb;
            vb = ((i / 200) % 3 == 0) ? 80 : ((i / 200) % 3 == 1) ? 30 : 55;
            rb = ((i / 200) % 3 == 0) ? 30 : ((i / 200) % 3 == 1) ? 80 : 55;
            cyc($urandom_range(0, 199) != 0,
                $urandom_range(0, 99) < 3,
                $urandom_range(0, 99) < vb,
                $urandom(), $urandom(),
                $urandom_range(0, 99) < rb);
        end
        idle(1'b0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
